// File: rtl/key_debounce_pair.sv
// Two-channel key debouncer: 2-flop synchronizer, stability counter and edge pulses per channel.
// Define KEY_DEBOUNCE_ACTIVE_LOW_EN to treat a low pin as pressed.
module key_debounce_pair #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_in,
  output logic [1:0] key_out,
  output logic [1:0] key_rise,
  output logic [1:0] key_fall
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {STABLE, PENDING} state_t;

  logic [1:0] key_pin;
  logic [1:0] sync0;
  logic [1:0] sync1;

`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
  assign key_pin = ~key_in;
`else
  assign key_pin = key_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= key_pin;
      sync1 <= sync0;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          differ;
    logic          accept;
    logic          out_q;
    logic          rise_q;
    logic          fall_q;

    assign differ = sync1[ch] ^ out_q;

    // Any agreeing sample returns to STABLE and clears the count.
    always_comb begin
      state_nxt = STABLE;
      cnt_nxt   = '0;
      accept    = 1'b0;
      case (state)
        STABLE: begin
          if (differ) begin
            if (LAST == '0) begin
              accept = 1'b1;
            end else begin
              cnt_nxt   = CW'(1);
              state_nxt = PENDING;
            end
          end
        end
        PENDING: begin
          if (differ) begin
            if (cnt == LAST) begin
              accept = 1'b1;
            end else begin
              cnt_nxt   = cnt + 1'b1;
              state_nxt = PENDING;
            end
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= STABLE;
        cnt    <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        out_q  <= out_q ^ accept;
        rise_q <= accept & ~out_q;
        fall_q <= accept & out_q;
      end
    end

    assign key_out[ch]  = out_q;
    assign key_rise[ch] = rise_q;
    assign key_fall[ch] = fall_q;
  end

endmodule

// File: tb/tb_key_debounce_pair.sv
// Directed self-checking bench for key_debounce_pair (STABLE_CYCLES=4).
// Observed vector per check is {key_out, key_rise, key_fall}.
module tb_key_debounce_pair;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_in = 2'b00;
  logic [1:0] key_out;
  logic [1:0] key_rise;
  logic [1:0] key_fall;

  int checks = 0;
  int errors = 0;

  key_debounce_pair #(.STABLE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_out  (key_out),
    .key_rise (key_rise),
    .key_fall (key_fall)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    key_in = 2'b11;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
        errors++;
        $display("[TB] FAIL reset_hold edge %0d got %b expected 000000", i, {key_out, key_rise, key_fall});
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
      errors++;
      $display("[TB] FAIL reset_first_cycle got %b expected 000000", {key_out, key_rise, key_fall});
    end
    key_in = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
      errors++;
      $display("[TB] FAIL reset_settle got %b expected 000000", {key_out, key_rise, key_fall});
    end
  endtask

  // Drive a held level and check latency: unchanged for 5 edges, new on the 6th, pulse gone on the 7th.
  task automatic test_press();
    key_in = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
        errors++;
        $display("[TB] FAIL press_wait edge %0d got %b expected 000000", i, {key_out, key_rise, key_fall});
      end
    end
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b01_01_00) begin
      errors++;
      $display("[TB] FAIL press_accept got %b expected 010100", {key_out, key_rise, key_fall});
    end
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b01_00_00) begin
      errors++;
      $display("[TB] FAIL press_pulse_end got %b expected 010000", {key_out, key_rise, key_fall});
    end
    key_in = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if ({key_out, key_rise, key_fall} !== 6'b01_00_00) begin
        errors++;
        $display("[TB] FAIL release_wait edge %0d got %b expected 010000", i, {key_out, key_rise, key_fall});
      end
    end
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b00_00_01) begin
      errors++;
      $display("[TB] FAIL release_accept got %b expected 000001", {key_out, key_rise, key_fall});
    end
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
      errors++;
      $display("[TB] FAIL release_pulse_end got %b expected 000000", {key_out, key_rise, key_fall});
    end
  endtask

  task automatic test_bounce();
    key_in = 2'b01;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) key_in = 2'b00;
      tick();
      checks++;
      if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
        errors++;
        $display("[TB] FAIL bounce edge %0d got %b expected 000000", i, {key_out, key_rise, key_fall});
      end
    end
  endtask

  task automatic test_simultaneous();
    key_in = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
      errors++;
      $display("[TB] FAIL both_wait got %b expected 000000", {key_out, key_rise, key_fall});
    end
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b11_11_00) begin
      errors++;
      $display("[TB] FAIL both_accept got %b expected 111100", {key_out, key_rise, key_fall});
    end
    checks++;
    if ((key_out[0] | key_out[1]) !== 1'b1) begin
      errors++;
      $display("[TB] FAIL both_or got %b expected 1", key_out[0] | key_out[1]);
    end
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b11_00_00) begin
      errors++;
      $display("[TB] FAIL both_pulse_end got %b expected 110000", {key_out, key_rise, key_fall});
    end
    key_in = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b00_00_11) begin
      errors++;
      $display("[TB] FAIL both_release got %b expected 000011", {key_out, key_rise, key_fall});
    end
    tick();
  endtask

  task automatic test_reset_mid_count();
    key_in = 2'b10;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
      errors++;
      $display("[TB] FAIL midrst_hold got %b expected 000000", {key_out, key_rise, key_fall});
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
        errors++;
        $display("[TB] FAIL midrst_wait edge %0d got %b expected 000000", i, {key_out, key_rise, key_fall});
      end
    end
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b10_10_00) begin
      errors++;
      $display("[TB] FAIL midrst_accept got %b expected 101000", {key_out, key_rise, key_fall});
    end
    key_in = 2'b00;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
      errors++;
      $display("[TB] FAIL midrst_release got %b expected 000000", {key_out, key_rise, key_fall});
    end
  endtask

`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
  task automatic test_active_low();
    key_in = 2'b11;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
        errors++;
        $display("[TB] FAIL actlow_idle edge %0d got %b expected 000000", i, {key_out, key_rise, key_fall});
      end
    end
    key_in = 2'b10;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b00_00_00) begin
      errors++;
      $display("[TB] FAIL actlow_wait got %b expected 000000", {key_out, key_rise, key_fall});
    end
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b01_01_00) begin
      errors++;
      $display("[TB] FAIL actlow_accept got %b expected 010100", {key_out, key_rise, key_fall});
    end
    tick();
    checks++;
    if ({key_out, key_rise, key_fall} !== 6'b01_00_00) begin
      errors++;
      $display("[TB] FAIL actlow_pulse_end got %b expected 010000", {key_out, key_rise, key_fall});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
    test_active_low();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_pair.md
KEY_DEBOUNCE_PAIR -- requirements
Module: key_debounce_pair

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL provide parameter STABLE_CYCLES, default 4, giving the number of consecutive disagreeing synchronized samples needed to accept a new level; legal range is 1..65535.
REQ-003 The block SHALL provide port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL provide port key_in, input, 2 bits: raw asynchronous key levels, bit 0 = a and bit 1 = b, feeding the downstream OR stage.
REQ-006 The block SHALL provide port key_out, output, 2 bits: debounced levels, driven directly from flops, used as the a and b operands downstream.
REQ-007 The block SHALL provide port key_rise, output, 2 bits: a one-cycle pulse per channel on each 0->1 change of key_out.
REQ-008 The block SHALL provide port key_fall, output, 2 bits: a one-cycle pulse per channel on each 1->0 change of key_out.

Function
REQ-009 Each channel SHALL be processed independently by an identical circuit with no cross-channel coupling.
REQ-010 Each channel SHALL pass key_in through a two-flop synchronizer (sync0, then sync1) before any other logic.
REQ-011 Each channel SHALL hold a counter of width clog2(STABLE_CYCLES+1).
- On a cycle where sync1 equals key_out, the counter clears to 0.
- On a cycle where they differ, the counter increments.
REQ-012 When sync1 differs from key_out and the counter equals STABLE_CYCLES-1, the channel SHALL, on that edge, toggle key_out and clear the counter.
REQ-013 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-014 The channel SHALL have two states, STABLE (counter 0) and PENDING (counter above 0).
- STABLE -> PENDING on the first disagreeing sample.
- PENDING -> STABLE on agreement (no output change) or on acceptance (output toggles).
REQ-015 Latency: if key_in changes before edge k and is held, key_out SHALL show the new value immediately after edge k+1+STABLE_CYCLES.
REQ-016 A disagreement lasting fewer than STABLE_CYCLES synchronized samples SHALL leave key_out unchanged and produce no pulses.
REQ-017 key_rise and key_fall SHALL be registered and asserted in exactly the first cycle key_out shows its new value, then deasserted on the next edge.
REQ-018 key_rise and key_fall for the same channel SHALL never be high together.
REQ-019 When both channels accept changes on the same edge, both key_out bits and both pulse outputs SHALL update in the same cycle.
REQ-020 With STABLE_CYCLES=1, a level SHALL be accepted on the first disagreeing synchronized sample.

Reset
REQ-021 While rst is high at a clock edge, the block SHALL clear sync0, sync1, the counters, key_out, key_rise and key_fall to 0, whatever key_in is.
REQ-022 Reset asserted mid-count SHALL discard the pending count.
REQ-023 After reset releases, acceptance of a held level SHALL take the full latency of REQ-015, counted from the first edge with rst low.
REQ-024 No asynchronous path from rst SHALL exist.

Configuration
REQ-025 With macro KEY_DEBOUNCE_ACTIVE_LOW_EN defined, key_in SHALL be inverted before sync0, so a low pin reads as pressed (1).
- Reset values are unchanged; the synchronizer flops still reset to 0.
- Consequence: with pins idle-high, the first post-reset samples already read 0 and no spurious pulse results.
REQ-026 Without KEY_DEBOUNCE_ACTIVE_LOW_EN, key_in SHALL be used at its true polarity.
- Pass/fail criteria and all other behaviour SHALL be identical with and without the macro.

Verification (STABLE_CYCLES=4, macro undefined unless stated)
REQ-027 The bench SHALL cover reset: key_in=2'b11, rst high for 3 edges -> key_out=00, key_rise=00, key_fall=00 during reset and for the first cycle after it.
REQ-028 The bench SHALL cover a clean press: key_in 00->01 before edge 10, then held -> key_out=01 after edge 15, key_rise=01 for exactly one cycle, key_out[1] stays 0.
REQ-029 The bench SHALL cover a bounce: key_in[0] high for 3 cycles, then low -> key_out, key_rise and key_fall stay 0 throughout.
REQ-030 The bench SHALL cover a simultaneous change: key_in 00->11 held -> both key_out bits rise on the same edge, key_rise=11 for one cycle, and the downstream OR output becomes 1 in that cycle.
REQ-031 The bench SHALL cover reset mid-count: key_in[1] goes high, then rst is pulsed 2 cycles later -> key_out stays 00, and key_out[1] sets exactly 1+STABLE_CYCLES edges after the first post-reset edge.
REQ-032 The bench SHALL cover the macro: KEY_DEBOUNCE_ACTIVE_LOW_EN defined, key_in held 11 through reset -> key_out=00 and no pulses; key_in=10 held -> key_out=01 after 5 edges with one key_rise[0] pulse.
